bfm_ahbl_apb4_bridge_param: RTL and testbench

//  Parametrised AHB-Lite slave to APB3/APB4 master bridge for the BFM bus path; next generation of the fixed 16-slot bridge.

---
 rtl/bfm_ahbl_apb4_bridge_param.sv | 183 ++++++++++++++++++
 tb/tb_bfm_ahbl_apb4_bridge_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bfm_ahbl_apb4_bridge_param.sv
// AHB-Lite slave to APB3/APB4 master bridge with parametrised slot decode,
// byte strobes, PREADY timeout and rejection of out-of-range or illegal transfers.
module bfm_ahbl_apb4_bridge_param #(
  parameter int TPD        = 1,
  parameter int NUM_SLOTS  = 16,
  parameter int SLOT_LSB   = 24,
  parameter int ADDR_WIDTH = 24,
  parameter int TIMEOUT    = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [NUM_SLOTS-1:0]  PSEL,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  TIMEOUT_EVT
);

  // TPD is kept for drop-in compatibility; outputs here carry no modelled delay.
  if (NUM_SLOTS < 1 || NUM_SLOTS > 16 || ADDR_WIDTH < 1 || ADDR_WIDTH > 32 ||
      SLOT_LSB < 0 || SLOT_LSB > 28 || TIMEOUT < 0 || TPD < 0) begin : g_bad_params
    $error("bfm_ahbl_apb4_bridge_param: parameter out of range");
  end

  localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t                  state;
  logic [3:0]              slot_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              lo_q;
  logic [1:0]              size_q;
  logic                    write_q;
  logic                    bad_q;
  logic [31:0]             count;

  logic       accept;
  logic       can_accept;
  logic [3:0] slot;
  logic       bad_req;
  logic [3:0] strb_next;
  logic       unused_inputs;

  assign slot       = HADDR[SLOT_LSB+3:SLOT_LSB];
  assign accept     = HSEL & HREADYIN & HTRANS[1];
  assign can_accept = (state == S_IDLE) || (state == S_DONE);
  assign bad_req    = (int'(slot) >= NUM_SLOTS) || (HSIZE > 3'd2);
  // Address bits outside the slot field and PADDR, and HTRANS[0], carry no meaning here.
  assign unused_inputs = ^{HADDR, HTRANS[0]};

  always_comb begin
    strb_next = 4'b0000;
    if (write_q) begin
      case (size_q)
        2'd0:    strb_next = 4'b0001 << lo_q;
        2'd1:    strb_next = lo_q[1] ? 4'b1100 : 4'b0011;
        default: strb_next = 4'b1111;
      endcase
    end
  end

  // NOTE: every output is a register cleared by the async reset, so an abort
  // mid-transfer drops PSEL/PENABLE immediately without waiting for HCLK.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state       <= S_IDLE;
      slot_q      <= '0;
      addr_q      <= '0;
      lo_q        <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      bad_q       <= 1'b0;
      count       <= '0;
      HREADYOUT   <= 1'b1;
      HRESP       <= 1'b0;
      HRDATA      <= '0;
      PSEL        <= '0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PENABLE     <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      TIMEOUT_EVT <= 1'b0;
    end else begin
      // NOTE: default-low here makes TIMEOUT_EVT a single-cycle pulse.
      TIMEOUT_EVT <= 1'b0;

      if (can_accept && accept) begin
        slot_q  <= slot;
        addr_q  <= HADDR[ADDR_WIDTH-1:0];
        lo_q    <= HADDR[1:0];
        size_q  <= HSIZE[1:0];
        write_q <= HWRITE;
        bad_q   <= bad_req;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_LATCH;
            HREADYOUT <= 1'b0;
          end
        end
        S_LATCH: begin
          PWDATA <= HWDATA;
          if (bad_q) begin
            state <= S_ERR1;
            HRESP <= 1'b1;
          end else begin
            state  <= S_SETUP;
            PSEL   <= NUM_SLOTS'(1) << slot_q;
            PADDR  <= addr_q;
            PWRITE <= write_q;
            PSTRB  <= strb_next;
            count  <= '0;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            if (PSLVERR) begin
              state <= S_ERR1;
              HRESP <= 1'b1;
            end else begin
              state     <= S_DONE;
              HREADYOUT <= 1'b1;
              if (!write_q) HRDATA <= PRDATA;
            end
          end else if (TIMEOUT > 0 && count == TIMEOUT_CNT) begin
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            TIMEOUT_EVT <= 1'b1;
            HRESP       <= 1'b1;
            state       <= S_ERR1;
          end else if (count != '1) begin
            count <= count + 32'd1;
          end
        end
        S_DONE: begin
          if (accept) begin
            state     <= S_LATCH;
            HREADYOUT <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ERR1: begin
          HREADYOUT <= 1'b1;
          state     <= S_ERR2;
        end
        S_ERR2: begin
          HRESP <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bfm_ahbl_apb4_bridge_param.sv
// Directed bench for the AHB-Lite to APB bridge: one 16-slot instance with an
// 8-cycle timeout, one 4-slot instance with the timeout disabled.
module tb_bfm_ahbl_apb4_bridge_param;

  logic        HCLK = 1'b0;
  logic        HRESETN;
  logic        hsel, sel_b;
  logic [31:0] HADDR, HWDATA, PRDATA;
  logic        HWRITE, HREADYIN, PREADY, PSLVERR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;

  always #5 HCLK = ~HCLK;

  logic        a_hready, a_hresp, a_pwrite, a_penable, a_tevt;
  logic [31:0] a_hrdata, a_pwdata;
  logic [15:0] a_psel;
  logic [23:0] a_paddr;
  logic [3:0]  a_pstrb;
  logic        b_hready, b_hresp, b_pwrite, b_penable, b_tevt;
  logic [31:0] b_hrdata, b_pwdata;
  logic [3:0]  b_psel;
  logic [23:0] b_paddr;
  logic [3:0]  b_pstrb;

  bfm_ahbl_apb4_bridge_param #(.TPD(1), .NUM_SLOTS(16), .SLOT_LSB(24), .ADDR_WIDTH(24), .TIMEOUT(8)) dut_a (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(hsel & ~sel_b), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
    .HREADYOUT(a_hready), .HRDATA(a_hrdata), .HRESP(a_hresp), .PSEL(a_psel), .PADDR(a_paddr),
    .PWRITE(a_pwrite), .PENABLE(a_penable), .PWDATA(a_pwdata), .PSTRB(a_pstrb),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .TIMEOUT_EVT(a_tevt));

  bfm_ahbl_apb4_bridge_param #(.TPD(1), .NUM_SLOTS(4), .SLOT_LSB(24), .ADDR_WIDTH(24), .TIMEOUT(0)) dut_b (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(hsel & sel_b), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
    .HREADYOUT(b_hready), .HRDATA(b_hrdata), .HRESP(b_hresp), .PSEL(b_psel), .PADDR(b_paddr),
    .PWRITE(b_pwrite), .PENABLE(b_penable), .PWDATA(b_pwdata), .PSTRB(b_pstrb),
    .PRDATA(PRDATA), .PREADY(1'b1), .PSLVERR(1'b0), .TIMEOUT_EVT(b_tevt));

  // Observation view of whichever instance is under test.
  logic        hready_o, hresp_o, pwrite_o, penable_o, tevt_o;
  logic [31:0] hrdata_o, pwdata_o;
  logic [15:0] psel_o;
  logic [23:0] paddr_o;
  logic [3:0]  pstrb_o;
  assign hready_o  = sel_b ? b_hready  : a_hready;
  assign hresp_o   = sel_b ? b_hresp   : a_hresp;
  assign pwrite_o  = sel_b ? b_pwrite  : a_pwrite;
  assign penable_o = sel_b ? b_penable : a_penable;
  assign tevt_o    = sel_b ? b_tevt    : a_tevt;
  assign hrdata_o  = sel_b ? b_hrdata  : a_hrdata;
  assign pwdata_o  = sel_b ? b_pwdata  : a_pwdata;
  assign psel_o    = sel_b ? {12'b0, b_psel} : a_psel;
  assign paddr_o   = sel_b ? b_paddr   : a_paddr;
  assign pstrb_o   = sel_b ? b_pstrb   : a_pstrb;

  int total = 0;
  int bad   = 0;

  int          low_cnt, acc_cnt, tevt_cnt, tevt_acc;
  logic        done, resp_low, resp_final, tevt_idle, seen_pwrite;
  logic [15:0] seen_psel;
  logic [23:0] seen_paddr;
  logic [3:0]  seen_pstrb;
  logic [31:0] seen_pwdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One AHB transfer; the bench plays the APB slave, raising PREADY after 'waits' low ACCESS cycles.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, input int waits, input logic err);
    @(negedge HCLK);
    hsel = 1'b1; HADDR = addr; HWRITE = wr; HTRANS = 2'b10; HSIZE = size;
    @(negedge HCLK);
    hsel = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    low_cnt = 0; acc_cnt = 0; tevt_cnt = 0; tevt_acc = -1; tevt_idle = 1'b0;
    done = 1'b0; resp_low = 1'b0; resp_final = 1'b0;
    seen_psel = '0; seen_paddr = '0; seen_pstrb = '0; seen_pwrite = 1'b0; seen_pwdata = '0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (cyc > 0) @(negedge HCLK);
      if (tevt_o) begin
        tevt_cnt++;
        tevt_acc  = acc_cnt;
        tevt_idle = (psel_o == 16'h0) && !penable_o;
      end
      if (hready_o) begin
        done = 1'b1;
        resp_final = hresp_o;
      end else begin
        low_cnt++;
        resp_low = hresp_o;
        if (psel_o != 16'h0) begin
          seen_psel  |= psel_o;
          seen_paddr  = paddr_o;
          seen_pstrb  = pstrb_o;
          seen_pwrite = pwrite_o;
        end
        if (penable_o) begin
          acc_cnt++;
          seen_pwdata = pwdata_o;
          PREADY  = (acc_cnt > waits);
          PSLVERR = err & PREADY;
        end else begin
          PREADY = 1'b0; PSLVERR = 1'b0;
        end
      end
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
    check("xfer_completed", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESETN = 1'b0; hsel = 1'b0; sel_b = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = 2'b00;
    HSIZE = 3'd0; HWDATA = '0; HREADYIN = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    // Reset values
    repeat (2) @(negedge HCLK);
    check("rst_ctrl", {27'b0, hready_o, hresp_o, penable_o, pwrite_o, tevt_o}, 32'b10000);
    check("rst_hrdata", hrdata_o, 32'h0);
    check("rst_psel", {16'b0, psel_o}, 32'h0);
    check("rst_paddr", {8'b0, paddr_o}, 32'h0);
    check("rst_pwdata", pwdata_o, 32'h0);
    check("rst_pstrb", {28'b0, pstrb_o}, 32'h0);
    HRESETN = 1'b1;
    repeat (2) @(negedge HCLK);
    check("idle_hready", {31'b0, hready_o}, 32'd1);

    // Word write, slot 3, zero wait
    xfer(32'h0300_0010, 1'b1, 3'd2, 32'hA5A5_0001, 0, 1'b0);
    check("ww_low", low_cnt, 3);
    check("ww_psel", {16'b0, seen_psel}, 32'h0008);
    check("ww_paddr", {8'b0, seen_paddr}, 32'h0000_0010);
    check("ww_pstrb", {28'b0, seen_pstrb}, 32'hF);
    check("ww_pwrite", {31'b0, seen_pwrite}, 32'd1);
    check("ww_pwdata", seen_pwdata, 32'hA5A5_0001);
    check("ww_resp", {31'b0, resp_final}, 32'd0);
    check("ww_hrdata_kept", hrdata_o, 32'h0);

    // Read slot 0 with five wait states
    PRDATA = 32'hDEAD_BEEF;
    xfer(32'h0000_0040, 1'b0, 3'd2, 32'h0, 5, 1'b0);
    check("rd_low", low_cnt, 8);
    check("rd_access", acc_cnt, 6);
    check("rd_psel", {16'b0, seen_psel}, 32'h0001);
    check("rd_pstrb", {28'b0, seen_pstrb}, 32'h0);
    check("rd_resp", {31'b0, resp_final}, 32'd0);
    check("rd_hrdata", hrdata_o, 32'hDEAD_BEEF);

    // Byte and halfword strobes
    xfer(32'h0500_0003, 1'b1, 3'd0, 32'h1100_0000, 0, 1'b0);
    check("b3_pstrb", {28'b0, seen_pstrb}, 32'b1000);
    check("b3_psel", {16'b0, seen_psel}, 32'h0020);
    xfer(32'h0500_0001, 1'b1, 3'd0, 32'h0000_2200, 0, 1'b0);
    check("b1_pstrb", {28'b0, seen_pstrb}, 32'b0010);
    xfer(32'h0500_0002, 1'b1, 3'd1, 32'h3333_0000, 0, 1'b0);
    check("h2_pstrb", {28'b0, seen_pstrb}, 32'b1100);
    xfer(32'h0500_0000, 1'b1, 3'd1, 32'h0000_4444, 0, 1'b0);
    check("h0_pstrb", {28'b0, seen_pstrb}, 32'b0011);

    // PSLVERR on write ack, then on a read (HRDATA must keep its value)
    xfer(32'h0100_0000, 1'b1, 3'd2, 32'h5555_5555, 0, 1'b1);
    check("sew_low", low_cnt, 4);
    check("sew_resp_err1", {31'b0, resp_low}, 32'd1);
    check("sew_resp_err2", {31'b0, resp_final}, 32'd1);
    @(negedge HCLK);
    check("sew_resp_clear", {31'b0, hresp_o}, 32'd0);
    PRDATA = 32'h1234_5678;
    xfer(32'h0100_0020, 1'b0, 3'd2, 32'h0, 0, 1'b1);
    check("ser_resp", {31'b0, resp_final}, 32'd1);
    check("ser_hrdata_kept", hrdata_o, 32'hDEAD_BEEF);

    // Illegal HSIZE rejected without PSEL
    xfer(32'h0100_0000, 1'b1, 3'd3, 32'h0, 0, 1'b0);
    check("hsz_low", low_cnt, 2);
    check("hsz_psel", {16'b0, seen_psel}, 32'h0);
    check("hsz_resp", {30'b0, resp_low, resp_final}, 32'b11);

    // PREADY arrives on the cycle count==TIMEOUT: completes normally
    xfer(32'h0200_0000, 1'b0, 3'd2, 32'h0, 8, 1'b0);
    check("tob_low", low_cnt, 11);
    check("tob_resp", {31'b0, resp_final}, 32'd0);
    check("tob_no_evt", tevt_cnt, 0);
    check("tob_hrdata", hrdata_o, 32'h1234_5678);

    // PREADY held low: timeout abort
    xfer(32'h0200_0000, 1'b1, 3'd2, 32'h0, 100, 1'b0);
    check("to_access", acc_cnt, 9);
    check("to_low", low_cnt, 12);
    check("to_evt_cnt", tevt_cnt, 1);
    check("to_evt_at", tevt_acc, 9);
    check("to_evt_apb_idle", {31'b0, tevt_idle}, 32'd1);
    check("to_resp", {30'b0, resp_low, resp_final}, 32'b11);

    // Four-slot instance: slot 3 valid, slot 7 rejected
    sel_b = 1'b1;
    PRDATA = 32'hCAFE_0003;
    xfer(32'h0300_0008, 1'b0, 3'd2, 32'h0, 0, 1'b0);
    check("b_s3_low", low_cnt, 3);
    check("b_s3_psel", {16'b0, seen_psel}, 32'h0008);
    check("b_s3_hrdata", hrdata_o, 32'hCAFE_0003);
    xfer(32'h0700_0000, 1'b1, 3'd2, 32'h0, 0, 1'b0);
    check("b_s7_low", low_cnt, 2);
    check("b_s7_psel", {16'b0, seen_psel}, 32'h0);
    check("b_s7_resp", {30'b0, resp_low, resp_final}, 32'b11);
    sel_b = 1'b0;

    // Asynchronous reset during ACCESS
    @(negedge HCLK);
    hsel = 1'b1; HADDR = 32'h0200_0004; HWRITE = 1'b1; HTRANS = 2'b10; HSIZE = 3'd2;
    @(negedge HCLK);
    hsel = 1'b0; HTRANS = 2'b00; HWDATA = 32'h7777_7777;
    done = 1'b0;
    for (int cyc = 0; cyc < 10 && !done; cyc++) begin
      @(negedge HCLK);
      done = penable_o;
    end
    check("ar_reached_access", {31'b0, done}, 32'd1);
    #2 HRESETN = 1'b0;
    #1;
    check("ar_psel", {16'b0, psel_o}, 32'h0);
    check("ar_ctrl", {29'b0, hready_o, hresp_o, penable_o}, 32'b100);
    @(negedge HCLK);
    HRESETN = 1'b1;
    xfer(32'h0200_0004, 1'b1, 3'd2, 32'h8888_8888, 0, 1'b0);
    check("ar_next_low", low_cnt, 3);
    check("ar_next_resp", {31'b0, resp_final}, 32'd0);
    check("ar_next_pwdata", seen_pwdata, 32'h8888_8888);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
